// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: sequential ALU that processes a WIDTH-bit operand pair four bits per clock.
// Results are produced LSB slice first, and a registered carry ripples between the slices.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   in_valid, in_ready  operand handshake. A new set is taken only while idle.
//   a, b, m, s, ci_n    operands, mode (0 = arithmetic, 1 = logic), op select, carry-in (active-low)
//   out_valid, out_ready  result handshake. The result is held until it is accepted.
//   y                   result
//   co_n, p_n, g_n      carry-out, group propagate, group generate (all inverted)
//   aeqb                all result bits are one
//   ovf                 signed overflow
module alu_nibble_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    input  logic [1:0]       s,
    input  logic             ci_n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             co_n,
    output logic             p_n,
    output logic             g_n,
    output logic             aeqb,
    output logic             ovf
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;     // holds b' in arithmetic mode and raw b in logic mode
    logic             m_q, m_d;
    logic [1:0]       s_q, s_d;
    logic             carry_q, carry_d;
    logic             carry0_q, carry0_d; // parallel ripple with cin forced to 0, for g_n
    logic             pall_q, pall_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             co_n_q, co_n_d;
    logic             p_n_q, p_n_d;
    logic             g_n_q, g_n_d;
    logic             aeqb_q, aeqb_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] b_prime;
    logic [3:0]       a_sl, b_sl, log_sl, res_sl;
    logic [4:0]       sum_sl, sum0_sl;
    logic [WIDTH-1:0] res_next;
    logic             pall_next;
    logic             last_slice;

    // Select the second operand as it is captured. This keeps the per-slice datapath uniform.
    always_comb begin
        b_prime = b;
        if (!m) begin
            unique case (s)
                2'b00:   b_prime = b;
                2'b01:   b_prime = ~b;
                2'b10:   b_prime = '0;
                default: b_prime = '1;
            endcase
        end
    end

    // Slice datapath. The operand registers shift right, so the current slice is always in [3:0].
    always_comb begin
        a_sl    = a_q[3:0];
        b_sl    = b_q[3:0];
        sum_sl  = {1'b0, a_sl} + {1'b0, b_sl} + {4'b0000, carry_q};
        sum0_sl = {1'b0, a_sl} + {1'b0, b_sl} + {4'b0000, carry0_q};
        unique case (s_q)
            2'b00:   log_sl = ~a_sl;
            2'b01:   log_sl = a_sl & b_sl;
            2'b10:   log_sl = a_sl | b_sl;
            default: log_sl = a_sl ^ b_sl;
        endcase
        res_sl     = m_q ? log_sl : sum_sl[3:0];
        // Each new slice enters at the top, so after NIB shifts slice 0 reaches bits [3:0].
        res_next   = (res_q >> 4) | (WIDTH'(res_sl) << (WIDTH - 4));
        pall_next  = pall_q & (&(a_sl ^ b_sl));
        last_slice = (cnt_q == CW'(NIB - 1));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        s_d      = s_q;
        carry_d  = carry_q;
        carry0_d = carry0_q;
        pall_d   = pall_q;
        res_d    = res_q;
        y_d      = y_q;
        co_n_d   = co_n_q;
        p_n_d    = p_n_q;
        g_n_d    = g_n_q;
        aeqb_d   = aeqb_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d  = StBusy;
                    cnt_d    = '0;
                    a_d      = a;
                    b_d      = b_prime;
                    m_d      = m;
                    s_d      = s;
                    carry_d  = ~ci_n;
                    carry0_d = 1'b0;
                    pall_d   = 1'b1;
                    res_d    = '0;
                end
            end
            StBusy: begin
                a_d      = a_q >> 4;
                b_d      = b_q >> 4;
                res_d    = res_next;
                carry_d  = sum_sl[4];
                carry0_d = sum0_sl[4];
                pall_d   = pall_next;
                cnt_d    = cnt_q + CW'(1);
                // The visible outputs change only here, so they stay put for the whole BUSY phase.
                if (last_slice) begin
                    state_d = StDone;
                    y_d     = res_next;
                    aeqb_d  = &res_next;
                    if (m_q) begin
                        co_n_d = 1'b1;
                        p_n_d  = 1'b1;
                        g_n_d  = 1'b1;
                        ovf_d  = 1'b0;
                    end else begin
                        co_n_d = ~sum_sl[4];
                        p_n_d  = ~pall_next;
                        g_n_d  = ~sum0_sl[4];
                        ovf_d  = (a_sl[3] == b_sl[3]) && (res_sl[3] != a_sl[3]);
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= 1'b0;
            s_q      <= 2'b00;
            carry_q  <= 1'b0;
            carry0_q <= 1'b0;
            pall_q   <= 1'b1;
            res_q    <= '0;
            y_q      <= '0;
            co_n_q   <= 1'b1;
            p_n_q    <= 1'b1;
            g_n_q    <= 1'b1;
            aeqb_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            s_q      <= s_d;
            carry_q  <= carry_d;
            carry0_q <= carry0_d;
            pall_q   <= pall_d;
            res_q    <= res_d;
            y_q      <= y_d;
            co_n_q   <= co_n_d;
            p_n_q    <= p_n_d;
            g_n_q    <= g_n_d;
            aeqb_q   <= aeqb_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign y         = y_q;
    assign co_n      = co_n_q;
    assign p_n       = p_n_q;
    assign g_n       = g_n_q;
    assign aeqb      = aeqb_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Testbench for alu_nibble_seq (WIDTH=16). Random and directed operand sets are checked
// against a whole-word arithmetic reference model through a scoreboard queue.
module tb_alu_nibble_seq;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned RW    = WIDTH + 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             m = 1'b0;
    logic [1:0]       s = 2'b00;
    logic             ci_n = 1'b1;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] y;
    logic             co_n, p_n, g_n, aeqb, ovf;

    int errors = 0;
    int checks = 0;
    logic [RW-1:0] exp_q[$];

    alu_nibble_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .m         (m),
        .s         (s),
        .ci_n      (ci_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .co_n      (co_n),
        .p_n       (p_n),
        .g_n       (g_n),
        .aeqb      (aeqb),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Result bundle layout: {y, co_n, p_n, g_n, aeqb, ovf}
    function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                            input logic mm, input logic [1:0] ms, input logic mci_n);
        logic [WIDTH-1:0] bp, ry;
        logic [WIDTH:0]   sum, sum0;
        logic             rco_n, rp_n, rg_n, rovf;
        if (mm) begin
            case (ms)
                2'b00:   ry = ~ma;
                2'b01:   ry = ma & mb;
                2'b10:   ry = ma | mb;
                default: ry = ma ^ mb;
            endcase
            rco_n = 1'b1; rp_n = 1'b1; rg_n = 1'b1; rovf = 1'b0;
        end else begin
            case (ms)
                2'b00:   bp = mb;
                2'b01:   bp = ~mb;
                2'b10:   bp = '0;
                default: bp = '1;
            endcase
            sum   = {1'b0, ma} + {1'b0, bp} + {{WIDTH{1'b0}}, ~mci_n};
            sum0  = {1'b0, ma} + {1'b0, bp};
            ry    = sum[WIDTH-1:0];
            rco_n = ~sum[WIDTH];
            rg_n  = ~sum0[WIDTH];
            rp_n  = ~(&(ma ^ bp));
            rovf  = (ma[WIDTH-1] == bp[WIDTH-1]) && (ry[WIDTH-1] != ma[WIDTH-1]);
        end
        return {ry, rco_n, rp_n, rg_n, &ry, rovf};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [RW-1:0] outs();
        return {y, co_n, p_n, g_n, aeqb, ovf};
    endfunction

    // Monitor: every completed output handshake is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(outs()), 64'hDEAD);
            end else begin
                check("scoreboard", 64'(outs()), 64'(exp_q.pop_front()));
            end
        end
    end

    // Issue one operand set and wait for out_valid. The latency from the accept edge is checked.
    // With hold=1, out_ready is left low on return. Otherwise it rises after 'stall' cycles.
    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tm,
                         input logic [1:0] ts, input logic tci_n, input int stall, input bit hold,
                         output logic [RW-1:0] got);
        int lat;
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        out_ready = (stall == 0) && !hold;
        a = ta; b = tb_; m = tm; s = ts; ci_n = tci_n;
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(ta, tb_, tm, ts, tci_n));
        #1;
        in_valid = 1'b0;
        a = $urandom(); b = $urandom();
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(NIB));
        got = outs();
        if (!hold) begin
            repeat (stall) @(posedge clk);
            #1 out_ready = 1'b1;
        end
    endtask

    logic [RW-1:0] got, held;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        // Reset state, checked while rst_n is still low
        check("reset_outputs", 64'(outs()), 64'({{WIDTH{1'b0}}, 5'b11100}));
        check("reset_hs", 64'({in_ready, out_valid}), 64'b10);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD 0x00FF + 0x0001
        issue(16'h00FF, 16'h0001, 1'b0, 2'b00, 1'b1, 0, 1'b0, got);
        check("add_y", 64'(got[RW-1:5]), 64'h0100);
        check("add_co_ovf", 64'({got[4], got[0]}), 64'b10);

        // SUB 0x1234 - 0x1234, both carry-in polarities
        issue(16'h1234, 16'h1234, 1'b0, 2'b01, 1'b0, 0, 1'b0, got);
        check("sub_y", 64'(got[RW-1:5]), 64'h0000);
        check("sub_co_aeqb", 64'({got[4], got[1]}), 64'b00);
        issue(16'h1234, 16'h1234, 1'b0, 2'b01, 1'b1, 0, 1'b0, got);
        check("subn_y", 64'(got[RW-1:5]), 64'hFFFF);
        check("subn_co_aeqb", 64'({got[4], got[1]}), 64'b11);

        // Signed overflow
        issue(16'h7FFF, 16'h0001, 1'b0, 2'b00, 1'b1, 0, 1'b0, got);
        check("ovf_y", 64'(got[RW-1:5]), 64'h8000);
        check("ovf_flags", 64'({got[4], got[3], got[0]}), 64'b111);

        // Logic XOR
        issue(16'hF0F0, 16'hFF00, 1'b1, 2'b11, 1'b0, 0, 1'b0, got);
        check("xor_y", 64'(got[RW-1:5]), 64'h0FF0);
        check("xor_flags", 64'(got[4:0]), 64'b11100);

        // Back-pressure: hold for 3 cycles while in_valid pulses arrive
        issue(16'hABCD, 16'h1357, 1'b0, 2'b00, 1'b0, 0, 1'b1, held);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = $urandom(); b = $urandom(); m = 1'b0; s = 2'b00;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check("stall_hold", 64'(outs()), 64'(held));
            check("stall_hs", 64'({out_valid, in_ready}), 64'b10);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_idle", 64'({out_valid, in_ready}), 64'b01);

        // Asynchronous reset during the second BUSY cycle
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; m = 1'b0; s = 2'b00; ci_n = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_hs", 64'({in_ready, out_valid}), 64'b10);
        check("midreset_outputs", 64'(outs()), 64'({{WIDTH{1'b0}}, 5'b11100}));
        @(negedge clk);
        rst_n = 1'b1;
        issue(16'h4321, 16'h1001, 1'b0, 2'b00, 1'b1, 0, 1'b0, got);
        check("post_reset_add", 64'(got[RW-1:5]), 64'h5322);

        // Random operand sets with random result back-pressure
        for (int i = 0; i < 60; i++) begin
            issue(WIDTH'($urandom()), WIDTH'($urandom()), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                  1'b0, got);
        end

        repeat (10) @(posedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_nibble_seq.md
ALU_NIBBLE_SEQ -- requirements
Module: alu_nibble_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits; legal values are multiples of 4 and at least 4.
REQ-002 SHALL derive localparam NIB = WIDTH/4: number of 4-bit slices, which equals the number of compute cycles.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: operand set offered.
REQ-006 SHALL have port in_ready, output, 1: block can accept operands.
REQ-007 SHALL have ports a, b, input, WIDTH: operands.
REQ-008 SHALL have port m, input, 1: mode; 0 = arithmetic, 1 = logic.
REQ-009 SHALL have port s, input, 2: operation select.
REQ-010 SHALL have port ci_n, input, 1: carry-in, active-low.
REQ-011 SHALL have port out_valid, output, 1: result available.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port y, output, WIDTH: result.
REQ-014 SHALL have port co_n, output, 1: carry-out, active-low.
REQ-015 SHALL have ports p_n and g_n, output, 1 each: word group propagate and group generate, both inverted.
REQ-016 SHALL have port aeqb, output, 1: all result bits are one.
REQ-017 SHALL have port ovf, output, 1: signed overflow.

Function
REQ-018 SHALL capture a, b, m, s and ci_n on the edge where in_valid && in_ready; inputs are ignored at all other times.
REQ-019 SHALL implement three states:
- IDLE -> BUSY on accept.
- BUSY -> DONE after NIB slice edges.
- DONE -> IDLE on out_ready.
REQ-020 SHALL drive in_ready = (state == IDLE), combinationally from the state.
REQ-021 SHALL process slice i (bits 4i+3..4i) on the i-th edge after acceptance, LSB slice first, propagating a registered ripple carry between slices.
REQ-022 SHALL raise out_valid exactly NIB cycles after the acceptance edge, with y, co_n, p_n, g_n, aeqb and ovf all valid in that same cycle.
REQ-023 SHALL hold out_valid and every result output stable while out_valid && !out_ready.
REQ-024 SHALL compute with internal carry-in cin = ~ci_n and operand b' chosen as follows:
- M=0, s=00: b' = B, result A+B+cin.
- M=0, s=01: b' = ~B, result A+~B+cin; ci_n=0 gives true A-B.
- M=0, s=10: b' = 0, result A+cin.
- M=0, s=11: b' = all-ones, result A-1+cin.
REQ-025 SHALL, in arithmetic mode, define per bit p_i = a_i ^ b'_i and g_i = a_i & b'_i, then:
- p_n = ~AND of all p_i.
- g_n = ~(carry-out of the word with cin forced to 0).
- co_n = ~(carry out of the MSB).
- ovf = (a[MSB] == b'[MSB]) && (y[MSB] != a[MSB]).
REQ-026 SHALL, in logic mode, produce s=00 ~A, s=01 A&B, s=10 A|B, s=11 A^B, and force co_n=1, p_n=1, g_n=1 and ovf=0.
REQ-027 SHALL drive aeqb = AND of all bits of y in both modes.
REQ-028 SHALL keep all arithmetic modulo 2^WIDTH; a carry out of the MSB SHALL appear only on co_n.
REQ-029 SHALL ignore in_valid while in BUSY or DONE; no queuing, no loss of the held result.
REQ-030 SHALL, with WIDTH=4, spend exactly one BUSY cycle before DONE.
REQ-031 SHALL leave y and the flags undefined-free while in BUSY: they hold their previous values until entry to DONE.

Reset
REQ-032 SHALL, on rst_n low, immediately enter IDLE regardless of clk, including mid-BUSY or mid-DONE, and discard any partial or held result.
REQ-033 SHALL set reset values y=0, co_n=1, p_n=1, g_n=1, aeqb=0, ovf=0, out_valid=0, internal carry=0, giving in_ready=1.
REQ-034 SHALL accept a new operand set on the first clk edge after rst_n deasserts.

Verification (WIDTH=16)
REQ-035 SHALL be verified with: ADD 0x00FF+0x0001, ci_n=1 -> y=0x0100, co_n=1, ovf=0, out_valid exactly 4 cycles after accept.
REQ-036 SHALL be verified with: SUB 0x1234-0x1234, ci_n=0 -> y=0x0000, co_n=0, aeqb=0; the same operands with ci_n=1 -> y=0xFFFF, co_n=1, aeqb=1.
REQ-037 SHALL be verified with: ADD 0x7FFF+0x0001, ci_n=1 -> y=0x8000, ovf=1, co_n=1, p_n=1.
REQ-038 SHALL be verified with: logic XOR 0xF0F0, 0xFF00 -> y=0x0FF0, co_n=1, p_n=1, g_n=1, ovf=0.
REQ-039 SHALL be verified with: out_ready held 0 for 3 cycles after out_valid -> outputs stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE on the next cycle.
REQ-040 SHALL be verified with: rst_n pulsed low during the 2nd BUSY cycle -> out_valid=0 and in_ready=1 immediately, all reset values present, and a fresh ADD after release completes correctly.
